// File: rtl/gcd_host_if.sv
// Bundle of operand, GCD-processor and result handshake signals for gcd_host.
// master = surrounding environment, slave = the host itself.
interface gcd_host_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] g_a;
  logic [3:0] g_b;
  logic       g_req;
  logic       g_avail;
  logic       g_busy;
  logic       g_valid;
  logic [3:0] g_gcd;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_a;
  logic [3:0] res_b;
  logic [3:0] res_gcd;
  logic       res_err;
  logic [7:0] done_cnt;

  modport master (
    output op_valid, op_a, op_b, g_busy, g_valid, g_gcd, res_ready,
    input  op_ready, g_a, g_b, g_req, g_avail,
           res_valid, res_a, res_b, res_gcd, res_err, done_cnt
  );

  modport slave (
    input  op_valid, op_a, op_b, g_busy, g_valid, g_gcd, res_ready,
    output op_ready, g_a, g_b, g_req, g_avail,
           res_valid, res_a, res_b, res_gcd, res_err, done_cnt
  );
endinterface

// File: rtl/gcd_host.sv
// GCD host: queues operand pairs, issues them one at a time to an external GCD
// processor, and holds each echoed result (or timeout error) for downstream.
module gcd_host #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 63
) (
  input logic       clk,
  input logic       rst_n,
  gcd_host_if.slave bus_io
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  fifo_a_q [DEPTH];
  logic [3:0]  fifo_b_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  g_a_q, g_a_d, g_b_q, g_b_d;
  logic        g_req_q, g_req_d, g_avail_q, g_avail_d;
  logic        res_valid_q, res_valid_d, res_err_q, res_err_d;
  logic [3:0]  res_a_q, res_a_d, res_b_q, res_b_d, res_gcd_q, res_gcd_d;
  logic [7:0]  done_cnt_q, done_cnt_d;
  logic        full_s, empty_s, push_s, pop_s, active_s, cap_s, tmo_hit_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_s    = bus_io.op_valid && !full_s;
  assign pop_s     = (state_q == S_IDLE) && !empty_s && !res_valid_q;
  assign active_s  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign cap_s     = ((state_q == S_REQ) && bus_io.g_busy && bus_io.g_valid) ||
                     ((state_q == S_WAIT) && bus_io.g_valid && g_avail_q);
  assign tmo_hit_s = active_s && (tmo_q == TMO_LAST) && !cap_s;

  assign bus_io.op_ready  = !full_s;
  assign bus_io.g_a       = g_a_q;
  assign bus_io.g_b       = g_b_q;
  assign bus_io.g_req     = g_req_q;
  assign bus_io.g_avail   = g_avail_q;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_a     = res_a_q;
  assign bus_io.res_b     = res_b_q;
  assign bus_io.res_gcd   = res_gcd_q;
  assign bus_io.res_err   = res_err_q;
  assign bus_io.done_cnt  = done_cnt_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a capture or timeout always ends in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) state_d = S_REQ;
        else       state_d = S_IDLE;
      end
      S_REQ: begin
        if (cap_s || tmo_hit_s)  state_d = S_HOLD;
        else if (bus_io.g_busy)  state_d = S_WAIT;
        else                     state_d = S_REQ;
      end
      S_WAIT: begin
        if (cap_s || tmo_hit_s) state_d = S_HOLD;
        else                    state_d = S_WAIT;
      end
      S_HOLD: begin
        if (!bus_io.g_valid && !bus_io.g_busy) state_d = S_IDLE;
        else                                   state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode from the next state so g_req/g_avail come out registered.
  always_comb begin
    g_req_d   = 1'b0;
    g_avail_d = 1'b0;
    case (state_d)
      S_REQ:   g_req_d   = 1'b1;
      S_WAIT:  g_avail_d = 1'b1;
      default: begin
        g_req_d   = 1'b0;
        g_avail_d = 1'b0;
      end
    endcase
  end

  // Datapath next-state: FIFO pointers, issued operands, timeout and result.
  always_comb begin
    wr_ptr_d    = push_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d    = pop_s  ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
    g_a_d       = g_a_q;
    g_b_d       = g_b_q;
    tmo_d       = tmo_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_gcd_d   = res_gcd_q;
    done_cnt_d  = done_cnt_q;

    if (pop_s) begin
      g_a_d = fifo_a_q[rd_ptr_q[AW-1:0]];
      g_b_d = fifo_b_q[rd_ptr_q[AW-1:0]];
    end else begin
      g_a_d = g_a_q;
      g_b_d = g_b_q;
    end

    if (state_d != state_q) tmo_d = 8'd0;
    else if (active_s)      tmo_d = tmo_q + 8'd1;
    else                    tmo_d = tmo_q;

    if (cap_s) begin
      res_valid_d = 1'b1;
      res_err_d   = 1'b0;
      res_a_d     = g_a_q;
      res_b_d     = g_b_q;
      res_gcd_d   = bus_io.g_gcd;
      done_cnt_d  = done_cnt_q + 8'd1;
    end else if (tmo_hit_s) begin
      res_valid_d = 1'b1;
      res_err_d   = 1'b1;
      res_a_d     = g_a_q;
      res_b_d     = g_b_q;
      res_gcd_d   = 4'd0;
      done_cnt_d  = done_cnt_q + 8'd1;
    end else if (res_valid_q && bus_io.res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Operand FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_a_q[i] <= 4'd0;
        fifo_b_q[i] <= 4'd0;
      end
    end else if (push_s) begin
      fifo_a_q[wr_ptr_q[AW-1:0]] <= bus_io.op_a;
      fifo_b_q[wr_ptr_q[AW-1:0]] <= bus_io.op_b;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      g_a_q       <= 4'd0;
      g_b_q       <= 4'd0;
      g_req_q     <= 1'b0;
      g_avail_q   <= 1'b0;
      tmo_q       <= 8'd0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_a_q     <= 4'd0;
      res_b_q     <= 4'd0;
      res_gcd_q   <= 4'd0;
      done_cnt_q  <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      g_a_q       <= g_a_d;
      g_b_q       <= g_b_d;
      g_req_q     <= g_req_d;
      g_avail_q   <= g_avail_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_gcd_q   <= res_gcd_d;
      done_cnt_q  <= done_cnt_d;
    end
  end
endmodule

// File: tb/tb_gcd_host.sv
// Randomized scoreboard bench for gcd_host with a behavioural GCD processor model.
module tb_gcd_host;
  localparam int DEPTH = 4;
  localparam int TMO   = 63;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic       err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_host_if bus ();
  gcd_host #(.DEPTH(DEPTH), .TMO(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_results = 0;
  int   pmode = 0;  // 0 normal, 1 busy+valid together, 2 never busy, 3 busy but never valid
  logic rr_random = 1'b0;
  logic rr_main = 1'b1;
  logic rr_rand = 1'b1;

  assign bus.res_ready = rr_random ? rr_rand : rr_main;

  function automatic logic [3:0] gcd_ref(input logic [3:0] a, input logic [3:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_op_ready"}, 32'(bus.op_ready), 32'd1);
    chk({tag, "_g_req"}, 32'(bus.g_req), 32'd0);
    chk({tag, "_g_avail"}, 32'(bus.g_avail), 32'd0);
    chk({tag, "_g_a"}, 32'(bus.g_a), 32'd0);
    chk({tag, "_g_b"}, 32'(bus.g_b), 32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_err"}, 32'(bus.res_err), 32'd0);
    chk({tag, "_res_a"}, 32'(bus.res_a), 32'd0);
    chk({tag, "_res_b"}, 32'(bus.res_b), 32'd0);
    chk({tag, "_res_gcd"}, 32'(bus.res_gcd), 32'd0);
    chk({tag, "_done_cnt"}, 32'(bus.done_cnt), 32'd0);
  endtask

  // Offer one pair; on acceptance queue the response the host must produce.
  task automatic push(input logic [3:0] a, input logic [3:0] b);
    int n;
    bit acc;
    res_t e;
    n = 0;
    acc = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    while (!acc && n < 200) begin
      acc = bus.op_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.op_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: op_ready stayed 0 for pair (%0d,%0d)", a, b);
    end else begin
      e.a = a;
      e.b = b;
      e.g = (pmode == 2) ? 4'd0 : gcd_ref(a, b);
      e.err = (pmode == 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_req(input string name, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 50) begin
      if (bus.g_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: g_req not seen within 50 cycles", name);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Behavioural GCD processor: reacts to g_req after a random delay.
  initial begin : proc
    int st;
    int cnt;
    logic [3:0] pa, pb;
    st = 0;
    cnt = 0;
    pa = 4'd0;
    pb = 4'd0;
    bus.g_busy = 1'b0;
    bus.g_valid = 1'b0;
    bus.g_gcd = 4'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        st = 0;
        bus.g_busy = 1'b0;
        bus.g_valid = 1'b0;
        bus.g_gcd = 4'd0;
      end else begin
        case (st)
          0: if (bus.g_req === 1'b1) begin
            pa = bus.g_a;
            pb = bus.g_b;
            if (pmode == 1) begin
              bus.g_busy = 1'b1;
              bus.g_valid = 1'b1;
              bus.g_gcd = gcd_ref(pa, pb);
              st = 3;
            end else if (pmode != 2) begin
              cnt = $urandom_range(0, 3);
              st = 1;
            end
          end
          1: if (cnt == 0) begin
            bus.g_busy = 1'b1;
            cnt = $urandom_range(0, 5);
            st = 2;
          end else cnt--;
          2: if (pmode != 3) begin
            if (cnt == 0) begin
              bus.g_valid = 1'b1;
              bus.g_gcd = gcd_ref(pa, pb);
              st = 3;
            end else cnt--;
          end
          default: if (bus.g_avail === 1'b0) begin
            bus.g_busy = 1'b0;
            bus.g_valid = 1'b0;
            st = 0;
          end
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #3;
    if (rr_random) rr_rand = ($urandom_range(0, 3) != 0);
  end

  // Monitor: each accepted result is popped from the scoreboard and compared.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      chk("req_avail_exclusive", 32'(bus.g_req & bus.g_avail), 32'd0);
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: a=%0d b=%0d gcd=%0d with empty scoreboard",
                   bus.res_a, bus.res_b, bus.res_gcd);
        end else begin
          e = exp_q.pop_front();
          n_results++;
          chk("res_a", 32'(bus.res_a), 32'(e.a));
          chk("res_b", 32'(bus.res_b), 32'(e.b));
          chk("res_gcd", 32'(bus.res_gcd), 32'(e.g));
          chk("res_err", 32'(bus.res_err), 32'(e.err));
          chk("done_cnt", 32'(bus.done_cnt), 32'(n_results % 256));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int bad;
    logic [3:0] sa, sb, sg;
    bus.op_valid = 1'b0;
    bus.op_a = 4'd0;
    bus.op_b = 4'd0;
    rr_main = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed (12,8).
    pmode = 0;
    push(4'd12, 4'd8);
    wait_req("t1_req", ok);
    if (ok) begin
      chk("t1_g_a", 32'(bus.g_a), 32'd12);
      chk("t1_g_b", 32'(bus.g_b), 32'd8);
    end
    drain("t1_drain");
    chk("t1_done_cnt", 32'(bus.done_cnt), 32'd1);

    // Zero operand forwarded untouched.
    push(4'd0, 4'd7);
    wait_req("t2_req", ok);
    if (ok) begin
      chk("t2_g_a", 32'(bus.g_a), 32'd0);
      chk("t2_g_b", 32'(bus.g_b), 32'd7);
    end
    drain("t2_drain");

    // Five back-to-back random pairs.
    for (int i = 0; i < 5; i++) push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain("t3_drain");
    chk("t3_done_cnt", 32'(bus.done_cnt), 32'd7);

    // Back-pressure: first result held, remaining four fill the FIFO.
    rr_main = 1'b0;
    for (int i = 0; i < 5; i++) push(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t4_fifo_full", 32'(bus.op_ready), 32'd0);
    sa = bus.res_a;
    sb = bus.res_b;
    sg = bus.res_gcd;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.res_a !== sa || bus.res_b !== sb || bus.res_gcd !== sg ||
          bus.res_valid !== 1'b1 || bus.g_req !== 1'b0 || bus.op_ready !== 1'b0) bad++;
    end
    chk("t4_hold_stable", 32'(bad), 32'd0);
    rr_main = 1'b1;
    drain("t4_drain");

    // Random stream with random downstream readiness.
    rr_random = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain("t5_drain");
    rr_random = 1'b0;
    @(posedge clk); #1;

    // Processor asserts busy and valid in the same cycle.
    pmode = 1;
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain("t6_drain");

    // Processor never busy: timeout after TMO cycles of g_req.
    pmode = 2;
    push(4'd9, 4'd3);
    wait_req("t7_req", ok);
    n = 0;
    while (bus.g_req === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t7_req_cycles", 32'(n), 32'(TMO));
    chk("t7_g_req_low", 32'(bus.g_req), 32'd0);
    drain("t7_drain");

    // Reset while waiting on the processor with two pairs queued.
    pmode = 3;
    push(4'd4, 4'd2);
    push(4'd6, 4'd3);
    push(4'd10, 4'd5);
    n = 0;
    while (bus.g_avail !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t8_in_wait", 32'(bus.g_avail), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("t8_rst");
    exp_q.delete();
    n_results = 0;
    pmode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.g_req !== 1'b0) bad++;
    end
    chk("t8_no_req_after_reset", 32'(bad), 32'd0);
    push(4'd9, 4'd6);
    wait_req("t8_req", ok);
    if (ok) begin
      chk("t8_g_a", 32'(bus.g_a), 32'd9);
      chk("t8_g_b", 32'(bus.g_b), 32'd6);
    end
    drain("t8_drain");
    chk("t8_done_cnt", 32'(bus.done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
